// File: rtl/reconf_fir_filter.sv
// ----------------------------------------------------------------------------
// reconf_fir_filter
//   10-tap reconfigurable FIR filter. One 3-bit signed sample enters per
//   600 kHz strobe; coefficients live in an internal 16-bit register file that
//   an external controller writes. The controller also sequences the
//   read -> multiply -> accumulate sweep by driving the RAM address and the
//   multiply / accumulate enables. The result is saturated to 16 bits and
//   registered on each sample strobe.
//
// Ports
//   iClk12M          : system clock, all logic on rising edge
//   iRsn             : asynchronous active-low reset
//   iEnSample600k    : one-cycle sample strobe (shift, clear acc, update output)
//   iCoeffUpdateFlag : 1 = coefficient update mode (writes allowed, reads blocked)
//   iCsnRam          : RAM chip select, active-low
//   iWrnRam          : RAM write enable, active-low (1 = read)
//   iEnMul           : multiply stage enable
//   iEnAddAcc        : accumulate stage enable
//   iAddrRam         : RAM address / tap index
//   iWtDtRam         : coefficient write data (two's complement)
//   iFirIn           : input sample (two's complement, -4..+3)
//   oFirOut          : saturated, registered filter output
// ----------------------------------------------------------------------------
module reconf_fir_filter #(
    parameter int unsigned TAPS  = 10,
    parameter int unsigned ACC_W = 24
) (
    input  logic        iClk12M,
    input  logic        iRsn,
    input  logic        iEnSample600k,
    input  logic        iCoeffUpdateFlag,
    input  logic        iCsnRam,
    input  logic        iWrnRam,
    input  logic        iEnMul,
    input  logic        iEnAddAcc,
    input  logic [5:0]  iAddrRam,
    input  logic [15:0] iWtDtRam,
    input  logic [2:0]  iFirIn,
    output logic [15:0] oFirOut
);

    localparam int unsigned IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned MUL_W = 19;
    localparam logic [5:0]  TAPS_A = 6'(TAPS);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-15){1'b1}}, 15'd0};

    logic signed [2:0]       r_tap [TAPS];
    logic signed [15:0]      r_mem [TAPS];
    logic signed [15:0]      r_rd_dt;
    logic        [5:0]       r_addr_d;
    logic signed [MUL_W-1:0] r_mul;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_addr_ok;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic        [IDX_W-1:0] w_addr_idx;
    logic        [IDX_W-1:0] w_tap_idx;
    logic signed [2:0]       w_tap_sel;
    logic signed [MUL_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_mul_ext;
    logic        [15:0]      w_sat;

    assign w_addr_ok  = (iAddrRam < TAPS_A);
    assign w_wr_en    = iCoeffUpdateFlag & ~iCsnRam & ~iWrnRam & w_addr_ok;
    assign w_rd_en    = ~iCoeffUpdateFlag & ~iCsnRam & iWrnRam;
    assign w_addr_idx = iAddrRam[IDX_W-1:0];

    // Out-of-range delayed addresses fall back to tap 0; their coefficient
    // read back as 0, so the product is 0 regardless.
    assign w_tap_idx  = (r_addr_d < TAPS_A) ? r_addr_d[IDX_W-1:0] : '0;
    assign w_tap_sel  = r_tap[w_tap_idx];

    assign w_prod     = $signed({{(MUL_W-16){r_rd_dt[15]}}, r_rd_dt})
                      * $signed({{(MUL_W-3){w_tap_sel[2]}}, w_tap_sel});
    assign w_mul_ext  = {{(ACC_W-MUL_W){r_mul[MUL_W-1]}}, r_mul};

    always_comb begin
        w_sat = r_acc[15:0];
        if (r_acc > SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (r_acc < SAT_MIN) begin
            w_sat = 16'h8000;
        end
    end

    // Delay line: tap[0] is the newest sample
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_tap[k] <= '0;
            end
        end else if (iEnSample600k) begin
            r_tap[0] <= iFirIn;
            for (int unsigned k = 1; k < TAPS; k++) begin
                r_tap[k] <= r_tap[k-1];
            end
        end
    end

    // Coefficient register file
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_addr_idx] <= iWtDtRam;
        end
    end

    // Stage 1: registered read; returns 0 when not a valid read cycle
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_rd_dt  <= '0;
            r_addr_d <= '0;
        end else if (w_rd_en) begin
            r_rd_dt  <= w_addr_ok ? r_mem[w_addr_idx] : '0;
            r_addr_d <= iAddrRam;
        end else begin
            r_rd_dt  <= '0;
        end
    end

    // Stage 2: multiply
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_mul <= '0;
        end else if (iEnMul) begin
            r_mul <= w_prod;
        end
    end

    // Stage 3: accumulate; the strobe restarts the sum (keeping a product
    // accumulated in the same cycle)
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_acc <= '0;
        end else if (iEnSample600k) begin
            r_acc <= iEnAddAcc ? w_mul_ext : '0;
        end else if (iEnAddAcc) begin
            r_acc <= r_acc + w_mul_ext;
        end
    end

    // Output register captures the saturated sum present before the strobe
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            oFirOut <= '0;
        end else if (iEnSample600k) begin
            oFirOut <= w_sat;
        end
    end

endmodule

// File: tb/tb_reconf_fir_filter.sv
// ----------------------------------------------------------------------------
// tb_reconf_fir_filter
//   Directed bench for reconf_fir_filter: coefficient load, impulse walk
//   across all taps, uniform tap patterns (in range and both saturation
//   limits), write protection, read blocking in update mode, and an
//   asynchronous reset in the middle of operation.
// ----------------------------------------------------------------------------
module tb_reconf_fir_filter;

    logic        clk;
    logic        rst_n;
    logic        en_smp;
    logic        upd;
    logic        csn;
    logic        wrn;
    logic        en_mul;
    logic        en_acc;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  fir_in;
    logic [15:0] fir_out;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    reconf_fir_filter #(
        .TAPS  (10),
        .ACC_W (24)
    ) dut (
        .iClk12M          (clk),
        .iRsn             (rst_n),
        .iEnSample600k    (en_smp),
        .iCoeffUpdateFlag (upd),
        .iCsnRam          (csn),
        .iWrnRam          (wrn),
        .iEnMul           (en_mul),
        .iEnAddAcc        (en_acc),
        .iAddrRam         (addr),
        .iWtDtRam         (wdata),
        .iFirIn           (fir_in),
        .oFirOut          (fir_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_coeff(input logic flag, input logic [5:0] a, input logic [15:0] d);
        upd   = flag;
        csn   = 1'b0;
        wrn   = 1'b0;
        addr  = a;
        wdata = d;
        tick();
        upd   = 1'b0;
        csn   = 1'b1;
        wrn   = 1'b1;
        addr  = '0;
        wdata = '0;
    endtask

    // Full controller sweep: addresses 0..9 on consecutive clocks, iEnMul
    // one clock behind the address, iEnAddAcc one clock behind iEnMul.
    task automatic sweep(input logic flag);
        for (int i = 0; i < 12; i++) begin
            upd    = flag;
            csn    = (i > 9);
            wrn    = 1'b1;
            addr   = (i <= 9) ? 6'(i) : 6'd0;
            en_mul = (i >= 1) && (i <= 10);
            en_acc = (i >= 2) && (i <= 11);
            tick();
        end
        upd    = 1'b0;
        csn    = 1'b1;
        addr   = '0;
        en_mul = 1'b0;
        en_acc = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic [2:0] s);
        fir_in = s;
        en_smp = 1'b1;
        tick();
        en_smp = 1'b0;
        fir_in = '0;
        tick();
    endtask

    task automatic fill_taps(input logic [2:0] s);
        for (int i = 0; i < 10; i++) begin
            strobe(s);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_smp = 1'b0;
        upd    = 1'b0;
        csn    = 1'b1;
        wrn    = 1'b1;
        en_mul = 1'b0;
        en_acc = 1'b0;
        addr   = '0;
        wdata  = '0;
        fir_in = '0;
        tick();
        tick();
        check("reset_out", fir_out, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Load coefficients 0x0A00 + k
        for (int k = 0; k < 10; k++) begin
            write_coeff(1'b1, 6'(k), 16'h0A00 + 16'(k));
        end

        // Impulse walking through every tap position: output = coeff[j]
        strobe(3'b001);
        for (int j = 0; j < 10; j++) begin
            sweep(1'b0);
            strobe(3'b000);
            check($sformatf("impulse_tap%0d", j), fir_out, 16'h0A00 + 16'(j));
        end

        // All taps +1: sum = 25645
        fill_taps(3'b001);
        sweep(1'b0);
        strobe(3'b001);
        check("all_plus1", fir_out, 16'h642D);

        // All taps -1: sum = -25645
        fill_taps(3'b111);
        sweep(1'b0);
        strobe(3'b111);
        check("all_minus1", fir_out, 16'h9BD3);

        // All taps +3: sum = 76935 -> positive clamp
        fill_taps(3'b011);
        sweep(1'b0);
        strobe(3'b011);
        check("sat_pos", fir_out, 16'h7FFF);

        // All taps -4: sum = -102580 -> negative clamp
        fill_taps(3'b100);
        sweep(1'b0);
        strobe(3'b100);
        check("sat_neg", fir_out, 16'h8000);

        // Ignored writes: flag low, address 12, and address 16 (aliases tap 0
        // if the range guard were missing)
        write_coeff(1'b0, 6'd0,  16'h1234);
        write_coeff(1'b1, 6'd12, 16'h5555);
        write_coeff(1'b1, 6'd16, 16'h1111);
        fill_taps(3'b000);
        strobe(3'b001);
        sweep(1'b0);
        strobe(3'b000);
        check("write_protect", fir_out, 16'h0A00);

        // Update mode blocks reads: sweep sums to zero
        fill_taps(3'b000);
        strobe(3'b001);
        sweep(1'b1);
        strobe(3'b001);
        check("read_blocked", fir_out, 16'h0000);

        // Same taps (1 at tap0 and tap1) with a normal sweep
        sweep(1'b0);
        strobe(3'b000);
        check("read_normal", fir_out, 16'h1401);

        // Asynchronous reset mid-sweep
        fill_taps(3'b011);
        for (int i = 0; i < 4; i++) begin
            upd    = 1'b0;
            csn    = 1'b0;
            wrn    = 1'b1;
            addr   = 6'(i);
            en_mul = (i >= 1);
            en_acc = (i >= 2);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("async_reset_out", fir_out, 16'h0000);
        csn    = 1'b1;
        en_mul = 1'b0;
        en_acc = 1'b0;
        addr   = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Coefficients are cleared: output stays 0 with non-zero taps
        for (int s = 0; s < 10; s++) begin
            strobe(3'b011);
            sweep(1'b0);
            strobe(3'b011);
            check($sformatf("post_reset_%0d", s), fir_out, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/reconf_fir_filter.md
Name: reconf_fir_filter

Overview:
- 10-tap reconfigurable FIR filter running on the 12 MHz system clock, processing one 3-bit signed sample per 600 kHz sample strobe.
- Coefficients are held in an internal 16-bit register-file RAM written by an external controller.
- The multiply/accumulate sweep is sequenced externally: the controller drives the RAM address plus multiply-enable and accumulate-enable strobes.
- The result is presented on a registered 16-bit saturated output.

Parameters:
- TAPS, 10, number of taps and coefficient RAM entries (addresses 0..TAPS-1).
- ACC_W, 24, accumulator width in bits (signed).

Ports:
- iClk12M  in  1  system clock, 12 MHz, all logic on its rising edge.
- iRsn  in  1  reset; asynchronous, active-low.
- iEnSample600k  in  1  one-cycle sample strobe (1 of every 20 clocks).
- iCoeffUpdateFlag  in  1  high = coefficient update mode (RAM writes allowed, reads blocked).
- iCsnRam  in  1  RAM chip select, active-low.
- iWrnRam  in  1  RAM write enable, active-low; high = read.
- iEnMul  in  1  multiply stage enable.
- iEnAddAcc  in  1  accumulate stage enable.
- iAddrRam  in  6  RAM address / tap index.
- iWtDtRam  in  16  coefficient write data (two's complement).
- iFirIn  in  3  input sample (two's complement, -4..+3).
- oFirOut  out  16  filter output (two's complement, saturated).

Behaviour:
- Reset (iRsn=0, async): delay line, all RAM entries, read register, address register, product, accumulator and oFirOut are cleared to 0.
- Delay line:
  - 10 x 3-bit signed taps; tap[0] is the newest sample.
  - On iEnSample600k=1: tap[0]<=iFirIn and tap[k]<=tap[k-1].
  - Otherwise the taps hold.
- RAM write:
  - Occurs when iCoeffUpdateFlag=1, iCsnRam=0, iWrnRam=0 and iAddrRam<TAPS: mem[iAddrRam]<=iWtDtRam on the clock edge.
  - Writes with the flag low, or with an address >=TAPS, are ignored.
- RAM read (stage 1):
  - When iCoeffUpdateFlag=0, iCsnRam=0, iWrnRam=1: RdDt<=mem[iAddrRam], or 0 if the address is >=TAPS. AddrD<=iAddrRam.
  - When iCsnRam=1, or in update mode: RdDt<=0.
  - Latency is 1 clock.
- Multiply (stage 2):
  - If iEnMul=1: Mul<=signed(RdDt) x signed(tap[AddrD]), a 19-bit signed product; tap index 0 is used when AddrD>=TAPS (coefficient is 0 then anyway).
  - If iEnMul=0: Mul holds.
- Accumulate (stage 3):
  - If iEnAddAcc=1: Acc<=Acc+sign-extended Mul.
  - On iEnSample600k=1: Acc is cleared (loads Mul instead if iEnAddAcc=1 in the same cycle).
- Output: on iEnSample600k=1, oFirOut<=sat16(Acc value before this edge), clamped to 0x7FFF / 0x8000. oFirOut holds between strobes.
- Sweep timing:
  - Controller presents addresses 0..9 on consecutive clocks.
  - iEnMul is asserted from the clock after address 0 until one clock after address 9 is removed.
  - iEnAddAcc follows one clock behind iEnMul.
  - Each product is therefore added exactly once; the sweep must complete between two sample strobes.
- Simultaneous events: a strobe during a sweep corrupts that sweep's result; no protection is provided. A write and a read cannot occur together (iWrnRam selects).
- Reset mid-sweep aborts the sweep; all state returns to 0 and the coefficients must be rewritten.

Test Plan:
1. Reset: assert iRsn=0 for 1 clock mid-operation -> oFirOut=0x0000 immediately; after 10 strobes with a full read sweep, output stays 0 because all coefficients are 0.
2. Coefficient load plus impulse:
   - Stimulus: write mem[k]=0x0A00+k (k=0..9); present iFirIn=001 at a strobe, then 000; run the sweep.
   - Required: oFirOut=0x0A00 at the next strobe.
   - Repeat the impulse at tap j -> oFirOut=0x0A00+j.
3. Positive saturation: fill all taps with 011 using the same coefficients -> sum is 76935, so oFirOut=0x7FFF.
4. Negative saturation: fill all taps with 100 -> sum is -102580, so oFirOut=0x8000.
5. Write protection: a write with iCoeffUpdateFlag=0, or to address 12, is ignored -> impulse test still gives 0x0A00.
6. Read blocked in update mode: a sweep with iCoeffUpdateFlag=1 -> accumulated result 0, so oFirOut=0x0000.
